// File: rtl/operand_forward_tracker.sv
// operand_forward_tracker
// Execute-stage operand forwarding with a private shift register of
// in-flight writebacks. Each source port takes its value from the youngest
// tracked producer of its register. If that producer is a load whose data has
// not arrived yet, the unit raises a load-use stall. The register file
// supplies the value once the producer has left the tracked window.

module operand_forward_tracker #(
   parameter  int XLEN   = 32,
   parameter  int NPORTS = 2,
   parameter  int DEPTH  = 3,
   localparam int SELW   = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall_ext,
   input  logic                   e_valid,
   input  logic                   e_regwrite,
   input  logic [4:0]             e_rd,
   input  logic                   e_is_load,
   input  logic [XLEN-1:0]        e_result,
   input  logic [XLEN-1:0]        m_late_data,
   input  logic [NPORTS*5-1:0]    rs_e,
   input  logic [NPORTS*XLEN-1:0] rf_data,
   output logic [NPORTS*XLEN-1:0] operand,
   output logic [NPORTS*SELW-1:0] fwd_sel,
   output logic                   stall
);

   // One tracked writeback. Array index i holds pipeline stage i+1 (index 0 = M).
   typedef struct packed {
      logic            vld;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic            rdy;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   logic [NPORTS-1:0] port_hazard;

   // Per-port resolution: scan from oldest to youngest so the youngest match is the one that sticks.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
      operand     = '0;
      fwd_sel     = '0;
      port_hazard = '0;
      for (int p = 0; p < NPORTS; p++) begin
         operand[p*XLEN +: XLEN] = rf_data[p*XLEN +: XLEN];
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_q[k].vld && (ent_q[k].rd == rs_e[p*5 +: 5]) && (ent_q[k].rd != 5'd0)) begin
               if (ent_q[k].rdy) begin
                  operand[p*XLEN +: XLEN] = ent_q[k].data;
                  fwd_sel[p*SELW +: SELW] = SELW'(k + 1);
                  port_hazard[p]          = 1'b0;
               end else begin
                  // A younger unready producer hides any older ready one.
                  operand[p*XLEN +: XLEN] = rf_data[p*XLEN +: XLEN];
                  fwd_sel[p*SELW +: SELW] = '0;
                  port_hazard[p]          = 1'b1;
               end
            end
         end
      end
   end

   assign stall = |port_hazard;

   // Next-state shift: age every entry by one stage, fill late load data on the
   // M->W move, and admit the E instruction unless it is held by a hazard.
   always_comb begin
      // NOTE: combinational logic uses blocking '=' so later statements see earlier updates within the same evaluation.
      ent_d = ent_q;
      if (!stall_ext) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            ent_d[k] = ent_q[k-1];
         end
         if (ent_q[0].vld && !ent_q[0].rdy) begin
            ent_d[1].data = m_late_data;
            ent_d[1].rdy  = 1'b1;
         end
         if (e_valid && e_regwrite && !stall) begin
            ent_d[0].vld  = 1'b1;
            ent_d[0].rd   = e_rd;
            ent_d[0].data = e_result;
            ent_d[0].rdy  = !e_is_load;
         end else begin
            ent_d[0] = '0;
         end
      end
   end

   // State register with synchronous reset; reset takes priority over the freeze.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every entry updates from the pre-edge values.
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            ent_q[k] <= '0;
         end
      end else begin
         ent_q <= ent_d;
      end
   end

endmodule

// File: doc/operand_forward_tracker.md
# operand_forward_tracker

Parametrised operand-forwarding unit for the execute stage of the 5-stage RISC-V pipeline, generalising the fixed 3-way ForwardBE-style operand mux. It keeps its own DEPTH-entry shift register of in-flight writebacks (rd, data, ready) behind E. It resolves NPORTS source operands, youngest producer first, and raises a load-use stall when the youngest match has no data yet. Sits between the register-file read outputs (latched into E) and the ALU source inputs.

## Interface
- XLEN, 32, datapath width
- NPORTS, 2, source-operand ports resolved in E
- DEPTH, 3, tracked post-E stages (stage 1 = M, 2 = W, 3 = one cycle past W); minimum 2
- SELW = $clog2(DEPTH+1), derived localparam, width of each select field
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_ext  in  1  global freeze (memory wait); tracker holds all state
- e_valid  in  1  instruction present in E
- e_regwrite  in  1  E instruction writes rd
- e_rd  in  5  destination register of E instruction
- e_is_load  in  1  E result is not available until the end of M
- e_result  in  XLEN  ALU result of E instruction
- m_late_data  in  XLEN  load data for the stage-1 entry, valid in the cycle it sits in stage 1
- rs_e  in  NPORTS*5  source register per port; port p at [5p+4:5p]
- rf_data  in  NPORTS*XLEN  register-file value per port
- operand  out  NPORTS*XLEN  resolved operand per port
- fwd_sel  out  NPORTS*SELW  0 = rf_data, k = stage k entry
- stall  out  1  load-use hazard; E and earlier stages must hold

## Operation
- Entry k (1..DEPTH) fields: vld, rd, data[XLEN], rdy.
- Match for port p at stage k: vld && rd == rs_p && rd != 0.
- Resolution per port: pick the lowest k that matches.
  - If that entry has rdy = 1: operand = data, fwd_sel = k.
  - If that entry has rdy = 0: port hazard; operand = rf_data, fwd_sel = 0.
  - If no stage matches: operand = rf_data, fwd_sel = 0.
- Older matches never override a younger one, even when the younger entry is not ready.
- stall = OR of port hazards. stall is combinational from current state and rs_e.
- Shift rule on each edge when stall_ext = 0:
  - Entry k+1 <= entry k for k = 1..DEPTH-1. The DEPTH entry is dropped (already written to the RF).
  - Entry 2 transition: if entry 1 is vld && !rdy, then entry 2 takes data = m_late_data and rdy = 1.
  - Entry 1 load when e_valid && e_regwrite && !stall: vld = 1, rd = e_rd, data = e_result, rdy = !e_is_load.
  - Otherwise entry 1 becomes a bubble (vld = 0).
  - e_rd = 0 is loaded as normal but never matches.
- stall_ext = 1: no entry changes; outputs still resolve from the held state.
- Priority: reset > stall_ext > shift.
- Only entry 1 can ever hold rdy = 0, so a stall lasts at most one cycle per load.

## Timing
- Reset value, next edge with reset = 1: all entries vld = 0, rdy = 0, rd = 0, data = 0.
- Outputs after reset: stall = 0, fwd_sel = 0, operand = rf_data.
- Latency:
  - ALU producer: forwardable to the next E instruction (0 bubbles).
  - Load producer: dependent instruction stalls 1 cycle, then sees fwd_sel = 2.
- Producer visibility: a producer stays visible for DEPTH cycles after leaving E. After that the register file supplies the value (write-first RF).
- Operand/select path is purely combinational: rs_e, rf_data and state to operand, fwd_sel and stall, in the same cycle.
- Reset mid-stall clears the hazard on the next edge. Any late load data not yet captured is discarded.

## Test plan
- After reset, rs_e = {x2, x1}, rf_data = {0x22, 0x11}: expect operand = {0x22, 0x11}, fwd_sel = 0, stall = 0.
- ALU x5 = 0xA5 in E, next cycle rs1 = x5: expect operand0 = 0xA5, fwd_sel0 = 1. One cycle later it resolves at fwd_sel0 = 2, then 3. The cycle after that, operand0 = rf_data.
- Load x7 in E, next cycle rs2 = x7 with m_late_data = 0xDEAD: expect stall = 1 for one cycle and a bubble inserted in entry 1. The following cycle gives stall = 0, operand1 = 0xDEAD, fwd_sel1 = 2.
- x3 written 0x1 then 0x2 in back-to-back E cycles; next instruction reads x3 on both ports: expect operand = {0x2, 0x2}, fwd_sel = {1, 1}.
- e_rd = x0 with e_result = 0xFF, then rs1 = x0 with rf_data = 0: expect operand0 = 0, fwd_sel0 = 0.
- Hold stall_ext = 1 for 3 cycles with x4 in entry 1: expect fwd_sel = 1 for x4 throughout. Release gives fwd_sel = 2 next cycle. Asserting reset while a load hazard is active gives stall = 0 next cycle.
